// File: rtl/conv_layer_sequencer.sv
// Layer-pass controller for one quantized conv block: steers a 32-bit load stream
// into bias/weight/input write ports, starts the conv, and counts its results.
module conv_layer_sequencer #(
    parameter int INPUT_CHANNELS  = 1,
    parameter int OUTPUT_CHANNELS = 32,
    parameter int KERNEL_SIZE     = 3,
    parameter int INPUT_WIDTH     = 30,
    parameter int INPUT_HEIGHT    = 30,
    localparam int NB    = OUTPUT_CHANNELS,
    localparam int NW    = OUTPUT_CHANNELS * INPUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
    localparam int NI    = INPUT_WIDTH * INPUT_HEIGHT,
    localparam int NO    = OUTPUT_CHANNELS * (INPUT_WIDTH - KERNEL_SIZE + 1) * (INPUT_HEIGHT - KERNEL_SIZE + 1),
    localparam int NB_AW = (NB > 1) ? $clog2(NB) : 1,
    localparam int NW_AW = (NW > 1) ? $clog2(NW) : 1,
    localparam int NI_AW = (NI > 1) ? $clog2(NI) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             go,
    input  logic             reload_params,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [31:0]      bias_data_in,
    output logic             bias_data_we,
    output logic [NB_AW-1:0] bias_data_addr,
    output logic [7:0]       weight_data_in,
    output logic             weight_data_we,
    output logic [NW_AW-1:0] weight_data_addr,
    output logic [7:0]       input_data_in,
    output logic             input_data_we,
    output logic [NI_AW-1:0] input_data_addr,
    output logic             conv_start,
    input  logic             conv_done,
    input  logic             conv_valid,
    output logic             busy,
    output logic             layer_done,
    output logic             count_err,
    output logic [31:0]      result_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_B = 3'd1;
    localparam logic [2:0] S_LOAD_W = 3'd2;
    localparam logic [2:0] S_LOAD_I = 3'd3;
    localparam logic [2:0] S_START  = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_FIN    = 3'd6;

    logic [2:0]  state;
    logic [31:0] ld_cnt;
    logic        beat_acc;
    logic [31:0] rc_next;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        if (en && (v != 32'hFFFF_FFFF))
            return v + 32'd1;
        return v;
    endfunction

    assign s_ready    = (state == S_LOAD_B) || (state == S_LOAD_W) || (state == S_LOAD_I);
    assign beat_acc   = s_valid && s_ready;
    assign busy       = (state != S_IDLE);
    assign layer_done = (state == S_FIN);
    // Result total including a conv_valid that coincides with conv_done.
    assign rc_next    = sat_inc(result_count, conv_valid);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= S_IDLE;
            ld_cnt           <= '0;
            bias_data_in     <= '0;
            bias_data_we     <= 1'b0;
            bias_data_addr   <= '0;
            weight_data_in   <= '0;
            weight_data_we   <= 1'b0;
            weight_data_addr <= '0;
            input_data_in    <= '0;
            input_data_we    <= 1'b0;
            input_data_addr  <= '0;
            conv_start       <= 1'b0;
            count_err        <= 1'b0;
            result_count     <= '0;
        end else begin
            bias_data_we   <= 1'b0;
            weight_data_we <= 1'b0;
            input_data_we  <= 1'b0;
            conv_start     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        count_err    <= 1'b0;
                        result_count <= '0;
                        ld_cnt       <= '0;
                        state        <= reload_params ? S_LOAD_B : S_LOAD_I;
                    end
                end
                S_LOAD_B: begin
                    if (beat_acc) begin
                        bias_data_we   <= 1'b1;
                        bias_data_addr <= ld_cnt[NB_AW-1:0];
                        bias_data_in   <= s_data;
                        if (ld_cnt == 32'(NB - 1)) begin
                            ld_cnt <= '0;
                            state  <= S_LOAD_W;
                        end else begin
                            ld_cnt <= ld_cnt + 32'd1;
                        end
                    end
                end
                S_LOAD_W: begin
                    if (beat_acc) begin
                        weight_data_we   <= 1'b1;
                        weight_data_addr <= ld_cnt[NW_AW-1:0];
                        weight_data_in   <= s_data[7:0];
                        if (ld_cnt == 32'(NW - 1)) begin
                            ld_cnt <= '0;
                            state  <= S_LOAD_I;
                        end else begin
                            ld_cnt <= ld_cnt + 32'd1;
                        end
                    end
                end
                S_LOAD_I: begin
                    if (beat_acc) begin
                        input_data_we   <= 1'b1;
                        input_data_addr <= ld_cnt[NI_AW-1:0];
                        input_data_in   <= s_data[7:0];
                        if (ld_cnt == 32'(NI - 1)) begin
                            ld_cnt <= '0;
                            state  <= S_START;
                        end else begin
                            ld_cnt <= ld_cnt + 32'd1;
                        end
                    end
                end
                // Start is registered here so it lands one cycle after the last input write.
                S_START: begin
                    conv_start <= 1'b1;
                    state      <= S_RUN;
                end
                S_RUN: begin
                    result_count <= rc_next;
                    if (conv_done) begin
                        count_err <= count_err | (rc_next != 32'(NO));
                        state     <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
Controller that drives one QuantizedConvReLU2d instance through a complete layer pass. It accepts a 32-bit valid/ready load stream and steers the beats into the conv block's bias, weight and input-feature write ports. It then issues the start pulse, counts conv_valid results, and reports completion and count errors. It sits between the layer-level DMA/stream fabric and the conv datapath.

Parameters:
INPUT_CHANNELS, 1, forwarded geometry; sets weight count.
OUTPUT_CHANNELS, 32, forwarded geometry; sets bias and weight count.
KERNEL_SIZE, 3, forwarded geometry.
INPUT_WIDTH, 30, padded input width.
INPUT_HEIGHT, 30, padded input height.
Derived (localparam): NB=OUTPUT_CHANNELS; NW=OUTPUT_CHANNELS*INPUT_CHANNELS*KERNEL_SIZE^2; NI=INPUT_WIDTH*INPUT_HEIGHT; NO=OUTPUT_CHANNELS*(INPUT_WIDTH-KERNEL_SIZE+1)*(INPUT_HEIGHT-KERNEL_SIZE+1).

Ports:
clk  in  1  single clock; all logic rising-edge.
rstn  in  1  asynchronous active-low reset.
go  in  1  one-cycle request to run a layer pass; ignored unless IDLE.
reload_params  in  1  sampled with go: 1 = load bias+weights then inputs; 0 = load inputs only.
s_data  in  32  load-stream beat; 8-bit items use s_data[7:0].
s_valid  in  1  load-stream valid.
s_ready  out  1  load-stream ready.
bias_data_in  out  32  to conv bias port.
bias_data_we  out  1
bias_data_addr  out  clog2(NB)
weight_data_in  out  8
weight_data_we  out  1
weight_data_addr  out  clog2(NW)
input_data_in  out  8
input_data_we  out  1
input_data_addr  out  clog2(NI)
conv_start  out  1  to conv start.
conv_done  in  1  from conv done.
conv_valid  in  1  from conv conv_valid.
busy  out  1  high in any state except IDLE.
layer_done  out  1  one-cycle pulse at end of pass.
count_err  out  1  sticky; set when result count != NO at conv_done; cleared by the next accepted go.
result_count  out  32  conv_valid pulses counted in the current pass.

Behaviour:
- Reset: state=IDLE. All outputs 0, including s_ready, every *_we, conv_start, busy, layer_done, count_err and result_count. Counters are cleared. Reset asserted mid-pass aborts immediately; no further writes or start are issued.
- FSM: IDLE -> (go & reload_params) LOAD_B -> LOAD_W -> LOAD_I. IDLE -> (go & !reload_params) LOAD_I. LOAD_I -> START -> RUN -> FIN -> IDLE.
- On an accepted go: count_err<=0, result_count<=0, load counter<=0.
- LOAD_B, LOAD_W and LOAD_I: s_ready=1 combinationally in these states only.
  - A beat is accepted when s_valid&s_ready.
  - On an accepted beat, the corresponding *_we is registered high for exactly 1 cycle, the next cycle. addr is the counter value, data is s_data (bias full 32 bits; weight/input s_data[7:0]; upper bits ignored).
  - The counter increments per beat. At beat count NB / NW / NI, the counter clears and the FSM advances on the same edge as the last accept.
  - Only one *_we is ever high in a given cycle.
  - s_valid low stalls the FSM with no write.
- START: conv_start=1 for exactly one cycle (registered). The last data write was committed the cycle before, so it precedes start.
- RUN: result_count increments on each conv_valid=1 cycle. It saturates at 2^32-1.
  - On conv_done=1: evaluate result_count plus any conv_valid in the same cycle; if that total != NO, set count_err. Then go to FIN.
- FIN: layer_done=1 for one cycle, then IDLE.
- conv_valid is counted only in RUN; it is ignored in every other state.
- conv_done outside RUN is ignored.
- go while busy is ignored; it has no queueing.
- The stream carries no framing; beat order is bias[0..NB-1], weights[0..NW-1], inputs[0..NI-1].
- No timeout: RUN waits indefinitely for conv_done.

Test Plan:
- Full load, OUTPUT_CHANNELS=2, INPUT_WIDTH=INPUT_HEIGHT=4, K=3, s_valid always 1 -> exactly 2 bias, 18 weight and 16 input writes with addr 0..N-1 and data matching the beats. Then one conv_start cycle after the last input write. Model emits 8 conv_valid then conv_done -> layer_done pulses once, result_count=8, count_err=0.
- s_valid toggled 1,0,1,0 across the load -> no writes on low cycles, addresses stay contiguous, total beats unchanged.
- go with reload_params=0 -> only 16 input writes, zero bias/weight writes, then conv_start.
- Model emits 7 conv_valid, and conv_done fires alone -> count_err=1 and layer_done pulses. The next go clears count_err.
- go pulsed during RUN and a spurious conv_done in IDLE -> no state change, no extra start, no layer_done.
- rstn asserted during LOAD_W at beat 5 -> all outputs 0 next edge and state IDLE. The following go reloads from bias addr 0.
